// File: rtl/jk_mod_counter.sv
// Mod-N up/down counter built from a bank of JK flip-flop stages.
// Each stage is driven with minimal-form J/K excitation derived from the desired next count.

module jk_stage (
  input  logic clk_i,
  input  logic rst_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o,
  output logic qbar_o
);

  logic q_q;
  logic qbar_q;

  // q and qbar are held as separate registers so both change on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q    <= 1'b0;
      qbar_q <= 1'b1;
    end else begin
      unique case ({j_i, k_i})
        2'b00: begin q_q <= q_q;  qbar_q <= qbar_q; end
        2'b01: begin q_q <= 1'b0; qbar_q <= 1'b1;   end
        2'b10: begin q_q <= 1'b1; qbar_q <= 1'b0;   end
        2'b11: begin q_q <= ~q_q; qbar_q <= ~qbar_q; end
      endcase
    end
  end

  assign q_o    = q_q;
  assign qbar_o = qbar_q;

endmodule

module jk_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bar,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_bar_q;
  logic [WIDTH-1:0] cnt_d;
  logic             illegal;
  logic             wrap_q;

  // Extra MSB keeps the range test valid when MODULUS == 2**WIDTH.
  assign illegal = ({1'b0, cnt_q} >= MOD_W);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = ({1'b0, load_val} < MOD_W) ? load_val : MAX_C;
    end else if (en) begin
      if (illegal)
        cnt_d = '0;
      else if (up_dn)
        cnt_d = (cnt_q == MAX_C) ? '0 : cnt_q + 1'b1;
      else
        cnt_d = (cnt_q == '0) ? MAX_C : cnt_q - 1'b1;
    end
  end

  assign j_vec = ~cnt_q & cnt_d;
  assign k_vec = cnt_q & ~cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_stage u_stage (
      .clk_i  (clk),
      .rst_i  (reset),
      .j_i    (j_vec[i]),
      .k_i    (k_vec[i]),
      .q_o    (cnt_q[i]),
      .qbar_o (cnt_bar_q[i])
    );
  end

  assign tc = en & ~load & ((up_dn & (cnt_q == MAX_C)) | (~up_dn & (cnt_q == '0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= tc;
  end

  assign count     = cnt_q;
  assign count_bar = cnt_bar_q;
  assign wrap      = wrap_q;

endmodule
